fpu_unpack: RTL
===============

Name: fpu_unpack

Overview:
- Operand front end of the FPU. It decodes a packed IEEE-754 double (db=1) or single (db=0, operand in op[31:0]) into sign, a 53-bit significand and a 13-bit two's-complement unbiased exponent, plus class flags.
- Subnormals are normalized iteratively, 1 bit per cycle, and the applied shift is reported as lz. This is the inverse of the rounder/packer path, which consumes significand/exponent/db and computes lz, TINY and OVF1.
- Valid/ready handshake on both sides.

Parameters:
- EXP_W, 13, exponent width (two's complement)
- SIG_W, 53, significand width, hidden bit at MSB
- LZ_W, 6, normalization shift count width

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand valid
- in_ready  output  1  block can accept an operand
- op  input  64  packed operand; single uses op[31:0]
- db  input  1  1 = double, 0 = single
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- sign  output  1  operand sign
- fu  output  SIG_W  significand 1.52; single fraction left-aligned (fu[52:29])
- eu  output  EXP_W  unbiased exponent
- lz  output  LZ_W  shift applied during subnormal normalization
- is_zero, is_inf, is_nan, is_snan, is_sub  output  1 each  class flags

Behaviour:
- Reset (asynchronous, any state, including mid-normalization): state IDLE, out_valid=0, in_ready=1, all data and flag outputs 0.
- FSM states: IDLE, NORM, DONE.
- IDLE:
  - in_ready=1.
  - Accept on in_valid&&in_ready. On the accept edge, capture sign and flags and load fu/eu.
  - Normal, zero, inf or NaN -> DONE. Subnormal -> NORM.
- Decode with bias B=1023 (db=1) or 127 (db=0), EMAX=1024 or 128:
  - Normal: fu = {1, frac aligned}, eu = E - B, lz = 0.
  - Zero (E=0, frac=0): fu = 0, eu = 0, lz = 0, is_zero = 1.
  - Inf: fu = 0, eu = EMAX, is_inf = 1.
  - NaN: fu = {1, frac aligned}, eu = EMAX, is_nan = 1. is_snan = 1 when the fraction MSB is 0.
  - Subnormal: fu = {0, frac aligned}, eu = 1 - B, lz = 0, is_sub = 1.
- NORM:
  - Each edge: fu <= fu<<1, eu <= eu-1, lz <= lz+1.
  - If the pre-shift fu[51]=1, go to DONE on that same edge.
  - in_ready=0; in_valid is ignored.
- Latency, counted from the accept cycle:
  - Non-subnormal: out_valid is high in the next cycle (1).
  - Subnormal with k leading zeros in the 53-bit field: out_valid is high 1+k cycles after accept. k max is 52 (double) or 23 (single).
- DONE:
  - out_valid=1. All outputs held stable while out_ready=0.
  - On out_valid&&out_ready, go to IDLE; in_ready rises the following cycle. There is no same-cycle bypass, so max throughput is 1 operand per 2 cycles.
- Arithmetic: eu is wrapping 13-bit two's complement; the minimum is -1074, so no overflow is possible. lz saturation is never reached (max 52).
- db, op and flags are registered at accept; input changes after accept have no effect.

Decomposition:
- Package fpu_unpack_pkg:
  - state enum {IDLE, NORM, DONE}
  - BIAS_D=1023, BIAS_S=127, EMAX_D=1024, EMAX_S=128
  - SIG_W, EXP_W, LZ_W constants
  - class-flag struct
- One combinational sub-module, fpu_unpack_classify: op, db -> sign, aligned fraction, biased E, class flags.
- FSM, shifter and counters stay in fpu_unpack.

Test Plan:
- Double 1.0, op=64'h3FF0000000000000, db=1, out_ready=1 -> 1 cycle later:
  - fu=53'h10000000000000, eu=13'h0000, lz=0, all flags 0.
  - in_ready returns to 1 the cycle after the transfer.
- Double min subnormal, op=64'h0000000000000001, db=1 -> out_valid 53 cycles after accept:
  - fu=53'h10000000000000, eu=13'h1BCE (-1074), lz=52, is_sub=1.
  - in_ready=0 throughout.
- Single min subnormal, op[31:0]=32'h00000001, db=0 -> 24 cycles after accept:
  - fu=53'h10000000000000, eu=13'h1F6B (-149), lz=23.
- Double sNaN, op=64'h7FF0000000000001 -> 1 cycle later:
  - is_nan=1, is_snan=1, eu=13'h0400, fu=53'h10000000000001.
- Single -0.0, op=32'h80000000, db=0 with out_ready=0 for 5 cycles:
  - sign=1, is_zero=1, outputs stable, out_valid held.
  - Transfer on the first cycle out_ready=1.
- Assert rst 10 cycles into a double subnormal normalization:
  - Immediately out_valid=0, fu=0, lz=0, in_ready=1.
  - A next operand 64'h3FF0000000000000 then decodes normally.

Source files
------------

// File: rtl/fpu_unpack_pkg.sv
// Shared types and constants for the FPU operand unpacker.
package fpu_unpack_pkg;

    localparam int EXP_W  = 13;          // unbiased exponent, two's complement
    localparam int SIG_W  = 53;          // significand, hidden bit at MSB
    localparam int LZ_W   = 6;           // normalization shift count
    localparam int FRAC_W = SIG_W - 1;   // aligned fraction field

    localparam int BIAS_D = 1023;
    localparam int BIAS_S = 127;
    localparam int EMAX_D = 1024;
    localparam int EMAX_S = 128;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        DONE
    } state_t;

    typedef struct packed {
        logic is_zero;
        logic is_inf;
        logic is_nan;
        logic is_snan;
        logic is_sub;
    } class_t;

endpackage

// File: rtl/fpu_unpack_classify.sv
// Combinational field split and classification of a packed double or single.
// Single fractions are left-aligned into the 52-bit fraction field so the
// downstream datapath is format-agnostic.
module fpu_unpack_classify
    import fpu_unpack_pkg::*;
(
    input  logic [63:0]       i_op,
    input  logic              i_db,
    output logic              o_sign,
    output logic [FRAC_W-1:0] o_frac,
    output logic [10:0]       o_exp,
    output class_t            o_cls
);

    logic w_exp_max;
    logic w_exp_zero;
    logic w_frac_zero;

    // Select sign/exponent/fraction fields for the operand format.
    always_comb begin
        // NOTE: every output gets a value on every path, so no latch is inferred.
        o_sign    = i_op[31];
        o_exp     = {3'b000, i_op[30:23]};
        o_frac    = {i_op[22:0], 29'd0};
        w_exp_max = (i_op[30:23] == 8'hFF);
        if (i_db) begin
            o_sign    = i_op[63];
            o_exp     = i_op[62:52];
            o_frac    = i_op[51:0];
            w_exp_max = (i_op[62:52] == 11'h7FF);
        end
    end

    assign w_exp_zero  = (o_exp == 11'd0);
    assign w_frac_zero = (o_frac == '0);

    // Derive the class flags; a NaN is signalling when the fraction MSB is clear.
    always_comb begin
        o_cls.is_zero = w_exp_zero && w_frac_zero;
        o_cls.is_sub  = w_exp_zero && !w_frac_zero;
        o_cls.is_inf  = w_exp_max && w_frac_zero;
        o_cls.is_nan  = w_exp_max && !w_frac_zero;
        o_cls.is_snan = w_exp_max && !w_frac_zero && !o_frac[FRAC_W-1];
    end

endmodule

// File: rtl/fpu_unpack.sv
// FPU operand front end: decodes a packed operand into sign, 1.52 significand,
// unbiased exponent and class flags; subnormals are normalized one bit per cycle.
module fpu_unpack
    import fpu_unpack_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      op,
    input  logic             db,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sign,
    output logic [SIG_W-1:0] fu,
    output logic [EXP_W-1:0] eu,
    output logic [LZ_W-1:0]  lz,
    output logic             is_zero,
    output logic             is_inf,
    output logic             is_nan,
    output logic             is_snan,
    output logic             is_sub
);

    state_t            r_state;
    state_t            w_next;
    logic              r_sign;
    logic [SIG_W-1:0]  r_fu;
    logic [EXP_W-1:0]  r_eu;
    logic [LZ_W-1:0]   r_lz;
    class_t            r_cls;

    logic              w_sign;
    logic [FRAC_W-1:0] w_frac;
    logic [10:0]       w_exp;
    class_t            w_cls;
    logic              w_accept;
    logic [EXP_W-1:0]  w_bias;
    logic [EXP_W-1:0]  w_emax;
    logic [SIG_W-1:0]  w_fu_load;
    logic [EXP_W-1:0]  w_eu_load;

    fpu_unpack_classify u_classify (
        .i_op   (op),
        .i_db   (db),
        .o_sign (w_sign),
        .o_frac (w_frac),
        .o_exp  (w_exp),
        .o_cls  (w_cls)
    );

    assign w_accept = in_valid && in_ready;
    assign w_bias   = db ? EXP_W'(BIAS_D) : EXP_W'(BIAS_S);
    assign w_emax   = db ? EXP_W'(EMAX_D) : EXP_W'(EMAX_S);

    // Initial significand/exponent for each operand class.
    always_comb begin
        w_fu_load = {1'b1, w_frac};
        w_eu_load = {2'b00, w_exp} - w_bias;
        if (w_cls.is_zero) begin
            w_fu_load = '0;
            w_eu_load = '0;
        end else if (w_cls.is_inf) begin
            w_fu_load = '0;
            w_eu_load = w_emax;
        end else if (w_cls.is_nan) begin
            w_eu_load = w_emax;
        end else if (w_cls.is_sub) begin
            w_fu_load = {1'b0, w_frac};
            w_eu_load = EXP_W'(1) - w_bias;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state and handshake decode; subnormals detour through NORM.
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = w_cls.is_sub ? NORM : DONE;
            end
            NORM: begin
                // Leading one reaches the hidden-bit position on this shift.
                if (r_fu[SIG_W-2]) w_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Datapath: capture on accept, then shift/decrement/count while normalizing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sign <= 1'b0;
            r_fu   <= '0;
            r_eu   <= '0;
            r_lz   <= '0;
            r_cls  <= '0;
        end else if (w_accept) begin
            r_sign <= w_sign;
            r_fu   <= w_fu_load;
            r_eu   <= w_eu_load;
            r_lz   <= '0;
            r_cls  <= w_cls;
        end else if (r_state == NORM) begin
            r_fu   <= r_fu << 1;
            r_eu   <= r_eu - EXP_W'(1);
            r_lz   <= r_lz + LZ_W'(1);
        end
    end

    assign sign    = r_sign;
    assign fu      = r_fu;
    assign eu      = r_eu;
    assign lz      = r_lz;
    assign is_zero = r_cls.is_zero;
    assign is_inf  = r_cls.is_inf;
    assign is_nan  = r_cls.is_nan;
    assign is_snan = r_cls.is_snan;
    assign is_sub  = r_cls.is_sub;

endmodule
